// File: rtl/corelet_seq.sv
//============================================================================
// Module      : corelet_seq
// Description : Instruction sequencer for the corelet (L0 + MAC array +
//               OFIFO + SFP) and its XMEM/PMEM SRAMs. A start pulse in IDLE
//               runs one weight-stationary pass. For each kernel position it
//               loads weights, streams activations and drains psums to PMEM.
//               It then accumulates the psums across kernel positions
//               through the SFP.
// Ports       : clk, reset (async, active low)
//               start              - begin a pass (IDLE only)
//               w_base/x_base      - XMEM weight / activation base
//               p_base             - PMEM psum base
//               ofifo_valid        - OFIFO holds a full row
//               l0_full            - L0 full flag
//               inst               - 35-bit corelet/SRAM instruction word
//               kij                - current kernel index
//               busy, done, err    - status (err is sticky until reset)
// Options     : define CTRL_RELU_EN to drive relu on the last accumulate of
//               each output vector; otherwise relu is tied low.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module corelet_seq #(
  parameter int row        = 8,
  parameter int col        = 8,
  parameter int len_kij    = 9,
  parameter int len_nij    = 36,
  parameter int len_onij   = 16,
  parameter int addr_w     = 11,
  parameter int inst_width = 35
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_w-1:0]     w_base,
  input  logic [addr_w-1:0]     x_base,
  input  logic [addr_w-1:0]     p_base,
  input  logic                  ofifo_valid,
  input  logic                  l0_full,
  output logic [inst_width-1:0] inst,
  output logic [3:0]            kij,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // CEN/WEN of both SRAMs high, everything else low.
  localparam logic [inst_width-1:0] IDLE_WORD = inst_width'(35'h1_800C_0000);
  localparam int CW = $clog2(row + col + len_nij + 2);
  localparam int KW = $clog2(len_kij);
  localparam int OW = $clog2(len_onij);

  typedef enum logic [3:0] {
    S_IDLE, S_WREAD, S_WKLOAD, S_WGAP, S_XREAD, S_EXEC, S_DRAIN, S_ACC, S_ACCT, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [KW-1:0]           k_q, k_d;
  logic [OW-1:0]           o_q, o_d;
  logic [3:0]              kij_q, kij_d;
  logic [addr_w-1:0]       wb_q, wb_d, xb_q, xb_d, pb_q, pb_d;
  logic [inst_width-1:0]   inst_q, inst_d;
  logic                    busy_q, done_q, err_q;
  logic                    xrd_now, prd_now, relu_now;
  logic [addr_w-1:0]       drain_addr;

  // The displayed word always reflects state_q, so "read this cycle" flags
  // become next cycle's l0_wr / acc (1-cycle SRAM latency).
  assign xrd_now = ((state_q == S_WREAD) && (cnt_q < CW'(col))) ||
                   ((state_q == S_XREAD) && (cnt_q < CW'(len_nij)));
  assign prd_now = (state_q == S_ACC);

`ifdef CTRL_RELU_EN
  assign relu_now = (state_q == S_ACC) && (k_q == KW'(len_kij - 1));
`else
  assign relu_now = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    o_d     = o_q;
    kij_d   = kij_q;
    wb_d    = wb_q;
    xb_d    = xb_q;
    pb_d    = pb_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_WREAD; cnt_d = '0; kij_d = '0;
        wb_d = w_base; xb_d = x_base; pb_d = p_base;
      end
      // col reads plus one tail cycle for the trailing l0_wr
      S_WREAD: if (cnt_q == CW'(col)) begin
        state_d = S_WKLOAD; cnt_d = '0;
      end else cnt_d = cnt_q + CW'(1);
      S_WKLOAD: if (cnt_q == CW'(col - 1)) begin
        state_d = S_WGAP; cnt_d = '0;
      end else cnt_d = cnt_q + CW'(1);
      S_WGAP: if (cnt_q == CW'(row + col - 1)) begin
        state_d = S_XREAD; cnt_d = '0;
      end else cnt_d = cnt_q + CW'(1);
      S_XREAD: if (cnt_q == CW'(len_nij)) begin
        state_d = S_EXEC; cnt_d = '0;
      end else cnt_d = cnt_q + CW'(1);
      S_EXEC: if (cnt_q == CW'(len_nij - 1)) begin
        state_d = S_DRAIN; cnt_d = '0;
      end else cnt_d = cnt_q + CW'(1);
      // cnt_q counts PMEM writes; advances only on OFIFO-valid cycles
      S_DRAIN: if (ofifo_valid) begin
        if (cnt_q == CW'(len_nij - 1)) begin
          cnt_d = '0;
          if (kij_q == 4'(len_kij - 1)) begin
            state_d = S_ACC; k_d = '0; o_d = '0;
          end else begin
            state_d = S_WREAD; kij_d = kij_q + 4'd1;
          end
        end else cnt_d = cnt_q + CW'(1);
      end
      S_ACC: if (k_q == KW'(len_kij - 1)) begin
        k_d = '0;
        if (o_q == OW'(len_onij - 1)) begin
          state_d = S_ACCT; cnt_d = '0;
        end else o_d = o_q + OW'(1);
      end else k_d = k_q + KW'(1);
      // cycle 0 carries the last acc, cycle 1 is the idle gap
      S_ACCT: if (cnt_q == CW'(1)) begin
        state_d = S_DONE; cnt_d = '0;
      end else cnt_d = cnt_q + CW'(1);
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    inst_d     = IDLE_WORD;
    inst_d[2]  = xrd_now;
    inst_d[33] = prd_now;
    inst_d[34] = relu_now;
    unique case (state_d)
      S_WREAD: if (cnt_d < CW'(col)) begin
        inst_d[19]   = 1'b0;
        inst_d[17:7] = wb_d + addr_w'(kij_d) * addr_w'(col) + addr_w'(cnt_d);
      end
      S_WKLOAD: begin inst_d[3] = 1'b1; inst_d[1:0] = 2'b01; end
      S_XREAD: if (cnt_d < CW'(len_nij)) begin
        inst_d[19]   = 1'b0;
        inst_d[17:7] = xb_d + addr_w'(cnt_d);
      end
      S_EXEC: begin inst_d[3] = 1'b1; inst_d[1:0] = 2'b10; end
      S_ACC: begin
        inst_d[32]    = 1'b0;
        inst_d[30:20] = pb_d + addr_w'(k_d) * addr_w'(len_nij) + addr_w'(o_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      o_q     <= '0;
      kij_q   <= '0;
      wb_q    <= '0;
      xb_q    <= '0;
      pb_q    <= '0;
      inst_q  <= IDLE_WORD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      o_q     <= o_d;
      kij_q   <= kij_d;
      wb_q    <= wb_d;
      xb_q    <= xb_d;
      pb_q    <= pb_d;
      inst_q  <= inst_d;
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
      err_q   <= err_q | (inst_q[2] & l0_full);
    end
  end

  // The drain handshake must follow ofifo_valid in the same cycle, so the
  // read/write fields are overlaid on the registered word here.
  assign drain_addr = pb_q + addr_w'(kij_q) * addr_w'(len_nij) + addr_w'(cnt_q);

  always_comb begin
    inst = inst_q;
    if ((state_q == S_DRAIN) && ofifo_valid) begin
      inst[32]    = 1'b0;
      inst[31]    = 1'b0;
      inst[30:20] = drain_addr;
      inst[6]     = 1'b1;
    end
  end

  assign kij  = kij_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_corelet_seq.sv
`default_nettype none

module tb_corelet_seq;

  localparam logic [34:0] IDLE_WORD = 35'h1_800C_0000;
`ifdef CTRL_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [10:0] w_base = '0, x_base = '0, p_base = '0;
  logic        ofifo_valid = 1'b0;
  logic        l0_full = 1'b0;
  logic [34:0] inst;
  logic [3:0]  kij;
  logic        busy, done, err;

  always #5 clk = ~clk;

  corelet_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .x_base(x_base), .p_base(p_base),
    .ofifo_valid(ofifo_valid), .l0_full(l0_full),
    .inst(inst), .kij(kij), .busy(busy), .done(done), .err(err)
  );

  int checks = 0, errors = 0;

  // scoreboard queues: {kij, addr} for XMEM reads / PMEM writes, addr for ACC reads
  logic [14:0] xq[$];
  logic [14:0] pq[$];
  logic [10:0] aq[$];

  int n_l0wr, n_kload, n_exec, n_done, n_pw, n_pr, n_acc, n_relu;
  int bad_fixed, bad_l0wr, bad_acc, bad_l0rd, bad_busy, bad_ofifo, bad_relu;
  int vmode = 0;
  int vcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=no event", name);
  endtask

  task automatic clear_stats();
    n_l0wr = 0; n_kload = 0; n_exec = 0; n_done = 0; n_pw = 0; n_pr = 0; n_acc = 0; n_relu = 0;
    bad_fixed = 0; bad_l0wr = 0; bad_acc = 0; bad_l0rd = 0; bad_busy = 0; bad_ofifo = 0; bad_relu = 0;
  endtask

  task automatic push_pass(input logic [10:0] w, input logic [10:0] x, input logic [10:0] p);
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 8; i++)  xq.push_back({4'(k), 11'(w + k * 8 + i)});
      for (int n = 0; n < 36; n++) xq.push_back({4'(k), 11'(x + n)});
      for (int m = 0; m < 36; m++) pq.push_back({4'(k), 11'(p + k * 36 + m)});
    end
    for (int o = 0; o < 16; o++)
      for (int k = 0; k < 9; k++) aq.push_back(11'(p + k * 36 + o));
  endtask

  // OFIFO-valid driver: always high, or toggling 1,0,1,0...
  initial forever begin
    @(posedge clk);
    #1;
    vcnt++;
    ofifo_valid = (vmode == 0) || ((vcnt % 2) == 1);
  end

  // monitor: pops expectations whenever the DUT presents an SRAM access
  initial begin
    logic [14:0] e;
    logic [10:0] a;
    logic        pw, pr, prev_xrd, prev_prd, exp_relu;
    prev_xrd = 1'b0;
    prev_prd = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_xrd = 1'b0;
        prev_prd = 1'b0;
      end else begin
        pw = !inst[32] && !inst[31];
        pr = !inst[32] &&  inst[31];
        if (inst[18] !== 1'b1 || inst[5:4] !== 2'b00) bad_fixed++;
        if (inst[2] !== prev_xrd) bad_l0wr++;
        if (inst[33] !== prev_prd) bad_acc++;
        if (inst[3] !== (inst[1:0] != 2'b00)) bad_l0rd++;
        if (done && busy) bad_busy++;
        if (inst[6] !== pw || (pw && !ofifo_valid)) bad_ofifo++;
        if (inst[2]) n_l0wr++;
        if (inst[1:0] == 2'b01) n_kload++;
        if (inst[1:0] == 2'b10) n_exec++;
        if (done) n_done++;
        if (!inst[19]) begin
          if (xq.size() == 0) miss("xmem_extra_read");
          else begin
            e = xq.pop_front();
            chk("xmem_addr", inst[17:7], e[10:0]);
            chk("xmem_kij", kij, e[14:11]);
          end
        end
        if (pw) begin
          n_pw++;
          if (pq.size() == 0) miss("pmem_extra_write");
          else begin
            e = pq.pop_front();
            chk("pmem_wr_addr", inst[30:20], e[10:0]);
            chk("pmem_wr_kij", kij, e[14:11]);
          end
        end
        if (pr) begin
          n_pr++;
          if (aq.size() == 0) miss("pmem_extra_read");
          else begin
            a = aq.pop_front();
            chk("acc_rd_addr", inst[30:20], a);
          end
        end
        if (inst[33]) begin
          n_acc++;
          exp_relu = RELU_ON && ((n_acc % 9) == 0);
          chk("relu", inst[34], exp_relu);
        end else if (inst[34]) bad_relu++;
        if (inst[34]) n_relu++;
        prev_xrd = !inst[19];
        prev_prd = pr;
      end
    end
  end

  task automatic run_pass(input logic [10:0] w, input logic [10:0] x, input logic [10:0] p,
                          input int vm, input bit seq, input bit inj, input bit exp_err);
    int inj_left;
    int t;
    bit exp_wr, exp_cen, exp_kl;
    clear_stats();
    push_pass(w, x, p);
    vmode = vm;
    @(posedge clk); #1;
    w_base = w; x_base = x; p_base = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (seq) begin
      for (int c = 1; c <= 18; c++) begin
        @(negedge clk);
        exp_cen = !(c <= 8);
        exp_wr  = (c >= 2) && (c <= 9);
        exp_kl  = (c >= 10) && (c <= 17);
        if (c == 1) chk("busy_after_start", busy, 1'b1);
        if (c == 18) chk("wgap_idle_word", inst, IDLE_WORD);
        else begin
          chk("seq_cen_xmem", inst[19], exp_cen);
          chk("seq_l0_wr", inst[2], exp_wr);
          chk("seq_l0_rd", inst[3], exp_kl);
          chk("seq_mac_op", inst[1:0], exp_kl ? 2'b01 : 2'b00);
        end
      end
    end
    inj_left = -1;
    for (t = 0; t < 6000 && n_done == 0; t++) begin
      @(negedge clk);
      if (inj && inj_left < 0 && !inst[19] && inst[17:7] == x && kij == 4'd1) begin
        chk("err_before_full", err, 1'b0);
        l0_full = 1'b1;
        inj_left = 4;
      end else if (inj_left > 0) begin
        inj_left--;
        if (inj_left == 0) l0_full = 1'b0;
      end
    end
    if (n_done == 0) miss("done_timeout");
    repeat (5) @(negedge clk);
    chk("done_pulses", n_done, 1);
    chk("pmem_writes", n_pw, 9 * 36);
    chk("acc_reads", n_pr, 144);
    chk("acc_count", n_acc, 144);
    chk("relu_count", n_relu, RELU_ON ? 16 : 0);
    chk("l0_wr_count", n_l0wr, 9 * 44);
    chk("kload_cycles", n_kload, 9 * 8);
    chk("exec_cycles", n_exec, 9 * 36);
    chk("xq_left", xq.size(), 0);
    chk("pq_left", pq.size(), 0);
    chk("aq_left", aq.size(), 0);
    chk("inv_fixed_bits", bad_fixed, 0);
    chk("inv_l0wr_align", bad_l0wr, 0);
    chk("inv_acc_align", bad_acc, 0);
    chk("inv_l0rd_op", bad_l0rd, 0);
    chk("inv_busy_done", bad_busy, 0);
    chk("inv_ofifo_rd", bad_ofifo, 0);
    chk("inv_relu_noacc", bad_relu, 0);
    chk("busy_after_pass", busy, 1'b0);
    chk("kij_hold", kij, 4'd8);
    chk("idle_after_pass", inst, IDLE_WORD);
    chk("err_after_pass", err, exp_err);
  endtask

  initial begin
    int t;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_inst", inst, IDLE_WORD);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_kij", kij, 4'd0);
    reset = 1'b1;

    // pass 1: plain bases, OFIFO always valid, cycle-exact start sequence
    run_pass(11'h010, 11'h100, 11'h200, 0, 1'b1, 1'b0, 1'b0);
    // pass 2: wrapping bases, OFIFO toggling, l0_full during activation loads
    run_pass(11'h7F8, 11'h7F0, 11'h7C0, 1, 1'b0, 1'b1, 1'b1);

    // err only clears on reset
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("err_cleared_by_reset", err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    // pass 3: abort during EXEC with an asynchronous reset
    clear_stats();
    push_pass(11'h020, 11'h300, 11'h400);
    vmode = 0;
    @(posedge clk); #1;
    w_base = 11'h020; x_base = 11'h300; p_base = 11'h400; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (t = 0; t < 500 && inst[1:0] != 2'b10; t++) @(negedge clk);
    if (inst[1:0] != 2'b10) miss("exec_timeout");
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_inst", inst, IDLE_WORD);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_kij", kij, 4'd0);
    xq.delete(); pq.delete(); aq.delete();
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_done", n_done, 0);
    chk("abort_stays_idle", inst, IDLE_WORD);
    chk("abort_no_activity", xq.size() + pq.size() + aq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
